// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong paddle datapath.
// Contents: FSM state / direction enums, screen geometry constants, btn decode.
package pong_pkg;

    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned SCREEN_W = 640;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } paddle_state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } paddle_dir_t;

    // 01 = up, 10 = down; idle and both-pressed both mean no motion.
    function automatic paddle_dir_t decode_btn(input logic [1:0] b);
        case (b)
            2'b01:   return DIR_UP;
            2'b10:   return DIR_DOWN;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controller bus: player buttons/pause in, paddle positions and flags out.
// Optional macro PADDLE_AI_EN adds ball_y / ai_en for computer-driven paddles.
//   master: drives btn, freeze (and ball_y, ai_en); observes y_pos and flags
//   slave : the paddle_ctrl side
interface paddle_ctrl_if #(
    parameter int unsigned N_PLAYERS  = 2,
    parameter int unsigned YBIT_WIDTH = 9
);
    logic [2*N_PLAYERS-1:0]              btn;
    logic                                freeze;
    logic [N_PLAYERS*(YBIT_WIDTH+1)-1:0] y_pos;
    logic [N_PLAYERS-1:0]                at_top;
    logic [N_PLAYERS-1:0]                at_bottom;
    logic [N_PLAYERS-1:0]                moving;
`ifdef PADDLE_AI_EN
    logic [YBIT_WIDTH:0]                 ball_y;
    logic [N_PLAYERS-1:0]                ai_en;

    modport master (output btn, freeze, ball_y, ai_en,
                    input  y_pos, at_top, at_bottom, moving);
    modport slave  (input  btn, freeze, ball_y, ai_en,
                    output y_pos, at_top, at_bottom, moving);
`else
    modport master (output btn, freeze,
                    input  y_pos, at_top, at_bottom, moving);
    modport slave  (input  btn, freeze,
                    output y_pos, at_top, at_bottom, moving);
`endif
endinterface

// File: rtl/paddle_channel.sv
// One paddle: direction decode, IDLE/SLOW/FAST ramp FSM, clamped y register, flags.
// Ports: clk, rst_n, tick_i (movement strobe), freeze_i, btn_i[1:0],
//        [PADDLE_AI_EN: ai_en_i, ball_y_i], y_o, at_top_o, at_bottom_o, moving_o.
module paddle_channel
    import pong_pkg::*;
#(
    parameter int unsigned YBIT_WIDTH      = 9,
    parameter int unsigned TOP_BOUNDARY    = 0,
    parameter int unsigned BOTTOM_BOUNDARY = 479,
    parameter int unsigned PADDLE_H        = 48,
    parameter int unsigned DY_SLOW         = 1,
    parameter int unsigned DY_FAST         = 4,
    parameter int unsigned RAMP_TICKS      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_i,
    input  logic                freeze_i,
    input  logic [1:0]          btn_i,
`ifdef PADDLE_AI_EN
    input  logic                ai_en_i,
    input  logic [YBIT_WIDTH:0] ball_y_i,
`endif
    output logic [YBIT_WIDTH:0] y_o,
    output logic                at_top_o,
    output logic                at_bottom_o,
    output logic                moving_o
);
    localparam int unsigned YW   = YBIT_WIDTH + 1;
    localparam int unsigned AW   = YBIT_WIDTH + 2;
    localparam int unsigned YMAX = BOTTOM_BOUNDARY - PADDLE_H;
    localparam int unsigned YMID = (TOP_BOUNDARY + YMAX) / 2;
    localparam int unsigned HW   = $clog2(RAMP_TICKS + 1);

    paddle_state_t state_q;
    paddle_dir_t   dir_q;
    paddle_dir_t   dir_c;
    logic [HW-1:0] hold_q;
    logic [YW-1:0] y_q;
    logic [YW-1:0] y_nxt_c;
    logic [AW-1:0] y_ext_c;
    logic [AW-1:0] step_c;
    logic [AW-1:0] sum_c;
    logic          move_c;
    logic          fresh_c;
    logic          at_top_q;
    logic          at_bottom_q;
    logic          moving_q;

    // Requested direction: buttons, or ball tracking when AI owns the paddle.
    always_comb begin
        dir_c = decode_btn(btn_i);
`ifdef PADDLE_AI_EN
        if (ai_en_i) begin
            // Compare with the offsets moved to the ball side so c-4 never underflows.
            if ((AW'(ball_y_i) + AW'(4)) < (AW'(y_q) + AW'(PADDLE_H / 2))) begin
                dir_c = DIR_UP;
            end else if (AW'(ball_y_i) > (AW'(y_q) + AW'(PADDLE_H / 2) + AW'(4))) begin
                dir_c = DIR_DOWN;
            end else begin
                dir_c = DIR_NONE;
            end
        end
`endif
    end

    // Step size and clamped candidate position for this tick.
    always_comb begin
        move_c  = (dir_c != DIR_NONE) && !freeze_i;
        fresh_c = (state_q == IDLE) || (dir_c != dir_q);
        step_c  = (!fresh_c && state_q == FAST) ? AW'(DY_FAST) : AW'(DY_SLOW);
        y_ext_c = AW'(y_q);
        sum_c   = y_ext_c + step_c;
        y_nxt_c = y_q;
        if (move_c) begin
            if (dir_c == DIR_UP) begin
                if (y_ext_c < (AW'(TOP_BOUNDARY) + step_c)) begin
                    y_nxt_c = YW'(TOP_BOUNDARY);
                end else begin
                    y_nxt_c = YW'(y_ext_c - step_c);
                end
            end else begin
                if (sum_c > AW'(YMAX)) begin
                    y_nxt_c = YW'(YMAX);
                end else begin
                    y_nxt_c = YW'(sum_c);
                end
            end
        end
    end

    // Ramp FSM and position; flags are registered alongside y so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dir_q       <= DIR_NONE;
            hold_q      <= '0;
            y_q         <= YW'(YMID);
            at_top_q    <= 1'b0;
            at_bottom_q <= 1'b0;
            moving_q    <= 1'b0;
        end else if (tick_i) begin
            y_q         <= y_nxt_c;
            at_top_q    <= (y_nxt_c == YW'(TOP_BOUNDARY));
            at_bottom_q <= (y_nxt_c == YW'(YMAX));
            if (!move_c) begin
                state_q  <= IDLE;
                hold_q   <= '0;
                moving_q <= 1'b0;
            end else if (fresh_c) begin
                // New press or reversal restarts the ramp.
                state_q  <= (RAMP_TICKS <= 1) ? FAST : SLOW;
                hold_q   <= HW'(1);
                dir_q    <= dir_c;
                moving_q <= 1'b1;
            end else if (state_q == SLOW) begin
                hold_q   <= hold_q + HW'(1);
                moving_q <= 1'b1;
                if ((hold_q + HW'(1)) >= HW'(RAMP_TICKS)) begin
                    state_q <= FAST;
                end
            end else begin
                moving_q <= 1'b1;
            end
        end
    end

    assign y_o         = y_q;
    assign at_top_o    = at_top_q;
    assign at_bottom_o = at_bottom_q;
    assign moving_o    = moving_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Multi-player paddle controller: shared movement-tick prescaler feeding
// N_PLAYERS independent paddle_channel instances.
// Ports: clk, rst_n (async active-low), bus (paddle_ctrl_if.slave: btn, freeze,
//        y_pos, at_top, at_bottom, moving). Macro PADDLE_AI_EN adds ball_y/ai_en.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned N_PLAYERS       = 2,
    parameter int unsigned YBIT_WIDTH      = 9,
    parameter int unsigned TOP_BOUNDARY    = 0,
    parameter int unsigned BOTTOM_BOUNDARY = 479,
    parameter int unsigned PADDLE_H        = 48,
    parameter int unsigned TICK_DIV        = 833333,
    parameter int unsigned DY_SLOW         = 1,
    parameter int unsigned DY_FAST         = 4,
    parameter int unsigned RAMP_TICKS      = 8
) (
    input logic         clk,
    input logic         rst_n,
    paddle_ctrl_if.slave bus
);
    localparam int unsigned YW    = YBIT_WIDTH + 1;
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] tick_cnt_q;
    logic             tick_c;

    assign tick_c = (tick_cnt_q == CNT_W'(TICK_DIV - 1));

    // Free-running prescaler; keeps counting while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick_c) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
        paddle_channel #(
            .YBIT_WIDTH      (YBIT_WIDTH),
            .TOP_BOUNDARY    (TOP_BOUNDARY),
            .BOTTOM_BOUNDARY (BOTTOM_BOUNDARY),
            .PADDLE_H        (PADDLE_H),
            .DY_SLOW         (DY_SLOW),
            .DY_FAST         (DY_FAST),
            .RAMP_TICKS      (RAMP_TICKS)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick_i      (tick_c),
            .freeze_i    (bus.freeze),
            .btn_i       (bus.btn[2*i +: 2]),
`ifdef PADDLE_AI_EN
            .ai_en_i     (bus.ai_en[i]),
            .ball_y_i    (bus.ball_y),
`endif
            .y_o         (bus.y_pos[i*YW +: YW]),
            .at_top_o    (bus.at_top[i]),
            .at_bottom_o (bus.at_bottom[i]),
            .moving_o    (bus.moving[i])
        );
    end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Multi-player paddle position controller for the pong datapath. Successor to the single-paddle block.
- Parametrised player count, paddle height and move-rate prescaler.
- Two-speed acceleration FSM per player; up and down steps are symmetric.
- Clamps against both screen boundaries with paddle height accounted for, and exposes boundary/motion flags to the renderer and collision logic.

Parameters:
- N_PLAYERS, 2, number of independent paddle channels
- YBIT_WIDTH, 9, y_pos bit index MSB (each position is YBIT_WIDTH+1 bits)
- TOP_BOUNDARY, 0, minimum paddle top y
- BOTTOM_BOUNDARY, 479, last visible screen row
- PADDLE_H, 48, paddle height in rows; YMAX = BOTTOM_BOUNDARY - PADDLE_H (431)
- TICK_DIV, 833333, clk cycles per movement tick (60 Hz at 50 MHz); must be >= 1
- DY_SLOW, 1, step per tick for the first RAMP_TICKS held ticks
- DY_FAST, 4, step per tick after the ramp
- RAMP_TICKS, 8, held ticks before switching to fast speed

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn  in  2*N_PLAYERS  per player i: bit 2i = up (y decreases), bit 2i+1 = down (y increases)
- freeze  in  1  game pause; suppresses all movement
- y_pos  out  N_PLAYERS*(YBIT_WIDTH+1)  paddle top y; player i in slice i
- at_top  out  N_PLAYERS  y_pos == TOP_BOUNDARY
- at_bottom  out  N_PLAYERS  y_pos == YMAX
- moving  out  N_PLAYERS  FSM state is not IDLE

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values:
  - every y_pos = (TOP_BOUNDARY+YMAX)/2 = 215
  - all FSMs IDLE, hold_cnt = 0, tick counter = 0
  - at_top = 0, at_bottom = 0, moving = 0
- Prescaler:
  - Shared counter runs 0..TICK_DIV-1. tick is asserted while counter == TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle.
  - The counter runs regardless of freeze.
- Registers update only on a clk edge where tick=1; between ticks all state holds.
- Direction decode per player: 01 = UP, 10 = DOWN, 00 or 11 = NONE.
- FSM per channel: IDLE, SLOW, FAST.
  - Transitions are evaluated only on tick.
  - NONE, or freeze=1: go to IDLE, hold_cnt = 0, no move.
  - From IDLE with UP/DOWN: move DY_SLOW, go to SLOW, hold_cnt = 1, record direction.
  - In SLOW with same direction: move DY_SLOW, hold_cnt++. When hold_cnt reaches RAMP_TICKS, go to FAST; the next tick uses DY_FAST.
  - In FAST with same direction: move DY_FAST.
  - Direction reversal from SLOW/FAST: treated as a fresh press. Move DY_SLOW, stay/enter SLOW, hold_cnt = 1.
  - Net effect: the first RAMP_TICKS moving ticks use DY_SLOW, all later ticks use DY_FAST.
- Arithmetic:
  - Compute in YBIT_WIDTH+2 bits; no wrap-around.
  - UP: if y < TOP_BOUNDARY+step then y = TOP_BOUNDARY, else y -= step.
  - DOWN: if y + step > YMAX then y = YMAX, else y += step.
  - Clamping does not change FSM state; holding against a wall keeps FAST.
- Output timing:
  - y_pos is a direct register.
  - at_top, at_bottom and moving are decoded from registered state, so they are valid the same cycle as y_pos.
- Reset mid-tick or mid-ramp: immediate return to reset values (asynchronous).
- Channels are fully independent; simultaneous presses on different players do not interact.

Optional Feature:
- Macro PADDLE_AI_EN.
- Defined:
  - Adds ports ball_y (in, YBIT_WIDTH+1) and ai_en (in, N_PLAYERS).
  - For player i with ai_en[i]=1, btn is ignored and a synthetic direction is used.
  - Paddle centre c = y + PADDLE_H/2.
  - ball_y < c-4 gives UP; ball_y > c+4 gives DOWN; otherwise NONE.
  - The synthetic direction feeds the same FSM, with the same ramp and clamp rules.
- Undefined: the ports are absent and all channels are manual only.

Decomposition:
- Package pong_pkg:
  - paddle_state_t enum {IDLE, SLOW, FAST}
  - paddle_dir_t enum {DIR_NONE, DIR_UP, DIR_DOWN}
  - btn decode function
  - screen constants 480/640
- Sub-module paddle_channel:
  - Contains one FSM, hold_cnt, y register and flags.
  - Instantiated N_PLAYERS times via generate.
  - The prescaler stays in paddle_ctrl and is broadcast to every channel.

Test Plan:
All scenarios use TICK_DIV=1 and defaults otherwise.
- Reset with btn=0: y_pos=215 on all players, moving=0, flags=0. Deassert rst_n, hold 5 cycles: y unchanged.
- Player0 btn=10 for 10 edges: 8×1 + 2×4, so y0=231, moving=1. Player1 stays at 215.
- Player0 btn=01 held 60 edges from 215: 8 slow reaches 207, 51 fast reaches 3, then clamps to 0; at_top=1. Another 3 edges: stays 0, state FAST.
- From FAST down, switch to btn=01: first step is 1 (reversal resets ramp). Then btn=11: no move, moving=0 next cycle.
- freeze=1 while btn=10: y constant, moving=0. Release freeze: first step is DY_SLOW.
- TICK_DIV=4, btn=10 for 8 cycles from reset: exactly 2 steps, y=217.
- Async reset asserted mid-ramp (FAST state) without a clk edge: y returns to 215 immediately.
- PADDLE_AI_EN build: ai_en[0]=1, ball_y=400. The paddle descends until ball_y lies within centre±4 (y ≈ 372..380), then moving=0. btn0 is ignored throughout.
